alu_shift_sequencer: RTL and testbench

Multi-cycle shift controller for the integer ALU. It accepts one SLL/SRL/SRA request at a time and applies the shift in chunks of at most MAX_SHIFT bits per clock, so the shifter logic stays within the core timing budget at the cost of latency. It sits between the execute-stage issue logic and the ALU writeback mux, and uses a valid/ready handshake on both sides.

---
 rtl/alu_shift_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_shift_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: multi-cycle SLL/SRL/SRA controller.
// Applies a requested shift in chunks of at most MAX_SHIFT bits per clock,
// with valid/ready handshakes on the request and result sides.
// Optional feature macro: SHIFT_SEQ_ZERO_BYPASS_EN. When it is defined, a
// zero shift amount skips the SHIFT state and lands directly in DONE.
module alu_shift_sequencer #(
  parameter int XLEN      = 32,
  parameter int SHAMT_W   = 5,
  parameter int MAX_SHIFT = 3,
  parameter int TAG_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [XLEN-1:0]    req_operand,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               flush,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [XLEN-1:0]    res_data,
  output logic [TAG_W-1:0]   res_tag,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [SHAMT_W-1:0] MAX_STEP = SHAMT_W'(MAX_SHIFT);

  state_t               state_q;
  state_t               state_d;
  logic [XLEN-1:0]      acc;
  logic [SHAMT_W-1:0]   rem;
  logic [1:0]           op_q;
  logic [TAG_W-1:0]     tag_q;

  logic                 accept;
  logic [SHAMT_W-1:0]   step;
  logic [SHAMT_W-1:0]   rem_next;
  logic [XLEN-1:0]      acc_shifted;

  // Chunk size for this cycle: whatever is left, capped at MAX_SHIFT.
  function automatic logic [SHAMT_W-1:0] step_amt(input logic [SHAMT_W-1:0] r);
    logic [SHAMT_W-1:0] s;
    s = (r < MAX_STEP) ? r : MAX_STEP;
    return s;
  endfunction

  // One chunk of the selected shift; reserved op code behaves as SLL.
  function automatic logic [XLEN-1:0] shift_by(
    input logic [XLEN-1:0]    v,
    input logic [1:0]         op,
    input logic [SHAMT_W-1:0] s
  );
    logic signed [XLEN-1:0] sv;
    logic        [XLEN-1:0] r;
    sv = $signed(v);
    case (op)
      OP_SRL:  r = v >> s;
      OP_SRA:  r = $unsigned(sv >>> s);
      default: r = v << s;
    endcase
    return r;
  endfunction

  assign accept      = req_valid && (state_q == IDLE) && !flush;
  assign step        = step_amt(rem);
  assign rem_next    = rem - step;
  assign acc_shifted = shift_by(acc, op_q, step);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
          state_d = (req_shamt == '0) ? DONE : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (rem_next == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Output decode from the registered state only; result fields read zero
  // outside DONE so intermediate shift values never appear on the bus.
  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    res_data  = '0;
    res_tag   = '0;
    case (state_q)
      IDLE:  req_ready = 1'b1;
      SHIFT: busy      = 1'b1;
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = acc;
        res_tag   = tag_q;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Operand capture on accept, then one chunk per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      rem   <= '0;
      op_q  <= '0;
      tag_q <= '0;
    end else if (accept) begin
      acc   <= req_operand;
      rem   <= req_shamt;
      op_q  <= req_op;
      tag_q <= req_tag;
    end else if (state_q == SHIFT) begin
      acc   <= acc_shifted;
      rem   <= rem_next;
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Testbench for alu_shift_sequencer: directed requests, a transaction-level
// model of expected handshake behaviour, and literal expectations for results.
module tb_alu_shift_sequencer;

  localparam int XLEN      = 32;
  localparam int SHAMT_W   = 5;
  localparam int MAX_SHIFT = 3;
  localparam int TAG_W     = 5;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_op = '0;
  logic [XLEN-1:0]    req_operand = '0;
  logic [SHAMT_W-1:0] req_shamt = '0;
  logic [TAG_W-1:0]   req_tag = '0;
  logic               flush = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [XLEN-1:0]    res_data;
  logic [TAG_W-1:0]   res_tag;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_shift_sequencer #(
    .XLEN(XLEN), .SHAMT_W(SHAMT_W), .MAX_SHIFT(MAX_SHIFT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_operand(req_operand), .req_shamt(req_shamt), .req_tag(req_tag),
    .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole shift computed in one go from the architectural definition.
  function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] x,
                                               input logic [4:0] sh);
    logic [31:0] fill;
    fill = ~(32'hFFFF_FFFF >> sh);
    case (op)
      2'b01:   return x >> sh;
      2'b10:   return (x >> sh) | (x[31] ? fill : 32'h0);
      default: return x << sh;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] sh);
    if (sh == 5'd0) return ZERO_LAT;
    return (int'(sh) + MAX_SHIFT - 1) / MAX_SHIFT;
  endfunction

  // Transaction model: one outstanding request, a countdown to its result.
  bit          m_active = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_wait   = 0;
    end else if (flush) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active = 1'b1;
        m_wait   = model_lat(req_shamt);
        m_res    = model_shift(req_op, req_operand, req_shamt);
        m_tag    = req_tag;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (res_ready) begin
      m_active = 1'b0;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("res_valid", 32'(res_valid), 32'(m_active && m_wait == 0));
    if (m_active && m_wait == 0) begin
      chk("res_data", res_data, m_res);
      chk("res_tag", 32'(res_tag), 32'(m_tag));
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [4:0] sh,
                      input logic [4:0] tag, output int acc_cyc);
    req_op      = op;
    req_operand = x;
    req_shamt   = sh;
    req_tag     = tag;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    acc_cyc     = cyc;
  endtask

  task automatic wait_res(input string name, input logic [31:0] exp_d, input logic [4:0] exp_t,
                          input int exp_lat, input int acc_cyc);
    int n;
    n = 0;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(res_valid), 32'd1);
    chk({name, "_data"}, res_data, exp_d);
    chk({name, "_tag"}, 32'(res_tag), 32'(exp_t));
    chk({name, "_lat"}, 32'(cyc - acc_cyc), 32'(exp_lat));
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_res_data"}, res_data, 32'd0);
    chk({name, "_res_tag"}, 32'(res_tag), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;

    // Pin the model against hand-computed values.
    chk("model_sll31", model_shift(2'b00, 32'h1, 5'd31), 32'h8000_0000);
    chk("model_sra7", model_shift(2'b10, 32'h8000_0000, 5'd7), 32'hFF00_0000);
    chk("model_srl7", model_shift(2'b01, 32'h8000_0000, 5'd7), 32'h0100_0000);
    chk("model_lat31", 32'(model_lat(5'd31)), 32'd11);
    chk("model_lat7", 32'(model_lat(5'd7)), 32'd3);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(2'b00, 32'h0000_0001, 5'd31, 5'd17, a);
    wait_res("sll31", 32'h8000_0000, 5'd17, 11, a);
    take();

    send(2'b10, 32'h8000_0000, 5'd7, 5'd3, a);
    wait_res("sra7", 32'hFF00_0000, 5'd3, 3, a);
    take();

    send(2'b01, 32'h8000_0000, 5'd7, 5'd4, a);
    wait_res("srl7", 32'h0100_0000, 5'd4, 3, a);
    take();

    send(2'b00, 32'h1234_5678, 5'd0, 5'd9, a);
    wait_res("sll0", 32'h1234_5678, 5'd9, ZERO_LAT, a);
    take();

    send(2'b11, 32'h0000_000F, 5'd4, 5'd30, a);
    wait_res("rsvd4", 32'h0000_00F0, 5'd30, 2, a);
    take();

    send(2'b10, 32'hF000_0000, 5'd3, 5'd1, a);
    wait_res("sra3", 32'hFE00_0000, 5'd1, 1, a);
    take();

    send(2'b10, 32'h7FFF_FFFF, 5'd30, 5'd31, a);
    wait_res("sra30", 32'h0000_0001, 5'd31, 10, a);
    take();

    // Backpressure: result must hold while res_ready stays low.
    send(2'b01, 32'hAAAA_0000, 5'd16, 5'd21, a);
    wait_res("bp", 32'h0000_AAAA, 5'd21, 6, a);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_data", res_data, 32'h0000_AAAA);
      chk("bp_hold_tag", 32'(res_tag), 32'd21);
      chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
    end
    take();
    chk("bp_release_req_ready", 32'(req_ready), 32'd1);

    // Flush during the second SHIFT cycle of a 20-bit shift.
    send(2'b00, 32'h0000_0001, 5'd20, 5'd2, a);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_req_ready", 32'(req_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("flush_no_result", 32'(res_valid), 32'd0);

    // A request presented together with flush is dropped.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_shamt = 5'd5;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_req_dropped_busy", 32'(busy), 32'd0);
    chk("flush_req_dropped_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a shift.
    @(posedge clk);
    #1;
    send(2'b00, 32'h0000_FFFF, 5'd20, 5'd7, a);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b01, 32'h0000_00F0, 5'd4, 5'd11, a);
    wait_res("post_reset", 32'h0000_000F, 5'd11, 2, a);
    take();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
